riscv_regfile: RTL and testbench
================================

Name: riscv_regfile

Overview:
- Integer register file and lock scoreboard for the RV32 core.
- Serves as the responder for the execute unit's register interface:
  - sinks its per-port lock requests and write-back ports;
  - drives the 32x32 register array and the per-register locked vector it reads.
- Tracks outstanding writers per register with saturating counters, so several in-flight results may target one register.

Parameters:
REGISTER_PORTS, riscv_pkg::REGISTER_PORTS, number of lock ports and number of write ports
LOCK_CNT_W, 2, width of each per-register outstanding-writer counter
RESET_VALUE, 32'h0, value loaded into x1..x31 on reset

Ports:
clock  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
register_lock_en  input  REGISTER_PORTS  per-port lock request valid
register_lock  input  REGISTER_PORTS x 6  per-port destination index; bits [4:0] select the register
register_write_en  input  REGISTER_PORTS  per-port write-back valid
register_write  input  REGISTER_PORTS x 6  per-port write-back index
register_write_data  input  REGISTER_PORTS x 32  per-port write-back data
register  output  32 x 32  registered architectural register values
register_locked  output  32  bit i=1 while register i has outstanding writers
err_index  output  1  one-cycle pulse: some valid port had index bit 5 set
err_write_conflict  output  1  one-cycle pulse: two or more write ports hit the same register
err_lock_overflow  output  1  one-cycle pulse: some counter saturated high
err_lock_underflow  output  1  one-cycle pulse: a write hit a register whose counter would go negative

Behaviour:
- Reset (reset==0, async, any time including mid-operation):
  - register[0]=0; register[1..31]=RESET_VALUE.
  - All counters=0, register_locked=0, all err_* outputs=0.
  - Lock and write inputs are ignored while reset is asserted.
  - First update occurs on the first rising edge after deassertion.
- x0:
  - register[0] is constant 0 and register_locked[0] is constant 0.
  - Writes and locks to index 0 are silently dropped; they cause no error.
- Index validity:
  - A valid port whose index has bit 5 set is dropped entirely.
  - err_index pulses on the next cycle.
- Writes:
  - When register_write_en[p] is set, register[idx] updates at the rising edge.
  - The new value is visible on the register output the following cycle; there is no combinational bypass.
  - If multiple write ports target one register in the same cycle, the highest port index wins the data.
  - err_write_conflict pulses in that case.
  - Every colliding port still counts as one writer for the counter decrement.
- Lock counter per register i, cnt[i] (LOCK_CNT_W bits):
  - L = number of valid lock ports targeting i this cycle; W = number of valid write ports targeting i.
  - next = cnt + L - W, computed at width LOCK_CNT_W+ceil(log2(REGISTER_PORTS))+2, signed.
  - next < 0: cnt<=0 and err_lock_underflow pulses.
  - next > 2^LOCK_CNT_W-1: cnt<=max and err_lock_overflow pulses.
  - Otherwise cnt<=next.
- Same-cycle lock and write to one register: net effect only (L=W=1 leaves cnt unchanged). The data is written.
- register_locked[i] is registered: register_locked[i] = (cnt[i] != 0) from the updated counter.
  - It rises the cycle after the lock request.
  - It falls the cycle after the final write-back.
- Writes with cnt=0 and no same-cycle lock still update data, and flag underflow.
- err_* outputs:
  - Registered, high exactly one cycle per offending cycle.
  - Consecutive offending cycles hold them high.
- Any number of ports may be active every cycle; there is no stall or backpressure output.

Test Plan:
- Reset check: drive reset=0 mid-stream after writing x5=32'hDEAD_BEEF → immediately register[5]=0 and register_locked=0. After release, register[0..31]=0 with RESET_VALUE=0.
- Single lock/write: cycle0 lock x7 → cycle1 register_locked[7]=1. Cycle3 write x7=32'h1234_5678 → cycle4 register[7]=32'h1234_5678 and register_locked[7]=0, no err_*.
- Multiple writers (REGISTER_PORTS=2): lock x3 twice, both ports in one cycle → cnt=2. Cycle+2 write x3=1 → still locked. Next cycle write x3=2 → unlocked, register[3]=2.
- Conflict and x0:
  - Both ports write x9 with 32'hA and 32'hB → register[9]=32'hB, err_write_conflict one-cycle pulse.
  - Write x0=32'hFFFF_FFFF → register[0]=0, no error.
- Saturation/underflow (LOCK_CNT_W=2):
  - Lock x4 four times across cycles → cnt saturates at 3, err_lock_overflow pulses on the 4th.
  - Write x10 with cnt=0 → data written, err_lock_underflow pulses, register_locked[10] stays 0.
- Bad index: lock port with index 6'h25 → dropped, err_index pulses, register_locked[5] unchanged.

Source files
------------

// File: rtl/riscv_regfile.sv
// -----------------------------------------------------------------------------
// riscv_pkg / riscv_regfile
//
// Integer register file and lock scoreboard for the RV32 core. The execute
// unit announces in-flight results through per-port lock requests and later
// retires them through per-port write-back ports. Each register carries a
// saturating count of outstanding writers, so several in-flight results may
// target the same register.
//
// Ports:
//   clock               core clock, all state updates on the rising edge
//   reset               asynchronous active-low reset
//   register_lock_en    per-port lock request valid
//   register_lock       per-port lock index (bit 5 set = invalid index)
//   register_write_en   per-port write-back valid
//   register_write      per-port write-back index (bit 5 set = invalid index)
//   register_write_data per-port write-back data
//   register            32 x 32 architectural register values (x0 reads 0)
//   register_locked     bit i high while register i has outstanding writers
//   err_index           pulse: a valid port carried an index with bit 5 set
//   err_write_conflict  pulse: two or more write ports hit one register
//   err_lock_overflow   pulse: a writer counter saturated at its maximum
//   err_lock_underflow  pulse: a writer counter would have gone negative
// -----------------------------------------------------------------------------
package riscv_pkg;
  localparam int REGISTER_PORTS = 2;
endpackage

module riscv_regfile #(
  parameter int          REGISTER_PORTS = riscv_pkg::REGISTER_PORTS,
  parameter int          LOCK_CNT_W     = 2,
  parameter logic [31:0] RESET_VALUE    = 32'h0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [REGISTER_PORTS-1:0]            register_lock_en,
  input  logic [REGISTER_PORTS-1:0][5:0]       register_lock,
  input  logic [REGISTER_PORTS-1:0]            register_write_en,
  input  logic [REGISTER_PORTS-1:0][5:0]       register_write,
  input  logic [REGISTER_PORTS-1:0][31:0]      register_write_data,
  output logic [31:0][31:0]                    register,
  output logic [31:0]                          register_locked,
  output logic                                 err_index,
  output logic                                 err_write_conflict,
  output logic                                 err_lock_overflow,
  output logic                                 err_lock_underflow
);

  // Counter arithmetic width: room for cnt + L - W plus a sign bit.
  localparam int CW = LOCK_CNT_W + $clog2(REGISTER_PORTS) + 2;
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = '1;

  // x0 has no storage: it is hard-wired to zero and never locked.
  logic [31:1][31:0]           reg_q, reg_d;
  logic [31:1][LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:1]                 locked_q;

  logic          err_index_d, err_conflict_d, err_ovf_d, err_unf_d;
  logic [CW-1:0] l_cnt, w_cnt, nxt;

  assign register        = {reg_q, 32'h0};
  assign register_locked = {locked_q, 1'b0};

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    err_index_d    = 1'b0;
    err_conflict_d = 1'b0;
    err_ovf_d      = 1'b0;
    err_unf_d      = 1'b0;
    reg_d          = reg_q;
    cnt_d          = cnt_q;
    l_cnt          = '0;
    w_cnt          = '0;
    nxt            = '0;

    for (int p = 0; p < REGISTER_PORTS; p++) begin
      if ((register_lock_en[p]  && register_lock[p][5]) ||
          (register_write_en[p] && register_write[p][5]))
        err_index_d = 1'b1;
    end

    for (int i = 1; i < 32; i++) begin
      l_cnt = '0;
      w_cnt = '0;
      // Ascending port order lets the highest-numbered writer win the data.
      for (int p = 0; p < REGISTER_PORTS; p++) begin
        if (register_lock_en[p] && !register_lock[p][5] &&
            register_lock[p][4:0] == 5'(i))
          l_cnt = l_cnt + CW'(1);
        if (register_write_en[p] && !register_write[p][5] &&
            register_write[p][4:0] == 5'(i)) begin
          w_cnt    = w_cnt + CW'(1);
          reg_d[i] = register_write_data[p];
        end
      end

      if (w_cnt > CW'(1))
        err_conflict_d = 1'b1;

      // Two's-complement difference; the top bit is the sign.
      nxt = CW'(cnt_q[i]) + l_cnt - w_cnt;
      if (nxt[CW-1]) begin
        cnt_d[i]  = '0;
        err_unf_d = 1'b1;
      end else if (nxt > CW'(CNT_MAX)) begin
        cnt_d[i]  = CNT_MAX;
        err_ovf_d = 1'b1;
      end else begin
        cnt_d[i]  = nxt[LOCK_CNT_W-1:0];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the register array is built from flops, not a RAM, so it can and
      // must take a defined reset value.
      reg_q              <= {31{RESET_VALUE}};
      cnt_q              <= '0;
      locked_q           <= '0;
      err_index          <= 1'b0;
      err_write_conflict <= 1'b0;
      err_lock_overflow  <= 1'b0;
      err_lock_underflow <= 1'b0;
    end else begin
      reg_q              <= reg_d;
      cnt_q              <= cnt_d;
      for (int i = 1; i < 32; i++)
        locked_q[i]      <= (cnt_d[i] != '0);
      err_index          <= err_index_d;
      err_write_conflict <= err_conflict_d;
      err_lock_overflow  <= err_ovf_d;
      err_lock_underflow <= err_unf_d;
    end
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// -----------------------------------------------------------------------------
// tb_riscv_regfile
//
// Directed bench for riscv_regfile with two ports, 2-bit writer counters and
// a zero reset value. Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, i.e. after the edge they depend on.
// -----------------------------------------------------------------------------
module tb_riscv_regfile;

  localparam int NP = 2;

  logic                  clock;
  logic                  reset;
  logic [NP-1:0]         register_lock_en;
  logic [NP-1:0][5:0]    register_lock;
  logic [NP-1:0]         register_write_en;
  logic [NP-1:0][5:0]    register_write;
  logic [NP-1:0][31:0]   register_write_data;
  logic [31:0][31:0]     register;
  logic [31:0]           register_locked;
  logic                  err_index;
  logic                  err_write_conflict;
  logic                  err_lock_overflow;
  logic                  err_lock_underflow;

  int n_checks = 0;
  int n_fails  = 0;

  riscv_regfile #(
    .REGISTER_PORTS (NP),
    .LOCK_CNT_W     (2),
    .RESET_VALUE    (32'h0)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .register_lock_en    (register_lock_en),
    .register_lock       (register_lock),
    .register_write_en   (register_write_en),
    .register_write      (register_write),
    .register_write_data (register_write_data),
    .register            (register),
    .register_locked     (register_locked),
    .err_index           (err_index),
    .err_write_conflict  (err_write_conflict),
    .err_lock_overflow   (err_lock_overflow),
    .err_lock_underflow  (err_lock_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // err bits packed as {index, conflict, overflow, underflow}
  function automatic logic [31:0] errs();
    return {28'h0, err_index, err_write_conflict, err_lock_overflow, err_lock_underflow};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    register_lock_en    = '0;
    register_lock       = '0;
    register_write_en   = '0;
    register_write      = '0;
    register_write_data = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lock(input int p, input logic [5:0] idx);
    register_lock_en[p] = 1'b1;
    register_lock[p]    = idx;
  endtask

  task automatic write(input int p, input logic [5:0] idx, input logic [31:0] d);
    register_write_en[p]   = 1'b1;
    register_write[p]      = idx;
    register_write_data[p] = d;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step();
    step();
    for (int i = 0; i < 32; i++) check($sformatf("por_reg%0d", i), register[i], 32'h0);
    check("por_locked", register_locked, 32'h0);
    check("por_errs", errs(), 32'h0);

    #2 reset = 1'b1;
    step();

    // Mid-stream asynchronous reset
    write(0, 6'd5, 32'hDEAD_BEEF);
    lock(1, 6'd6);
    step();
    idle();
    check("pre_rst_reg5", register[5], 32'hDEAD_BEEF);
    check("pre_rst_locked", register_locked, 32'h0000_0040);
    #2 reset = 1'b0;
    #1;
    check("async_rst_reg5", register[5], 32'h0);
    check("async_rst_locked", register_locked, 32'h0);
    #2 reset = 1'b1;
    step();
    for (int i = 0; i < 32; i++) check($sformatf("rst_reg%0d", i), register[i], 32'h0);

    // Single lock / write-back
    lock(0, 6'd7);
    step();
    idle();
    check("lock7_locked", register_locked, 32'h0000_0080);
    check("lock7_errs", errs(), 32'h0);
    step();
    step();
    write(0, 6'd7, 32'h1234_5678);
    step();
    idle();
    check("wr7_data", register[7], 32'h1234_5678);
    check("wr7_locked", register_locked, 32'h0);
    check("wr7_errs", errs(), 32'h0);

    // Two outstanding writers on x3
    lock(0, 6'd3);
    lock(1, 6'd3);
    step();
    idle();
    check("lock3x2_locked", register_locked, 32'h0000_0008);
    step();
    write(0, 6'd3, 32'h1);
    step();
    idle();
    check("wr3a_data", register[3], 32'h1);
    check("wr3a_locked", register_locked, 32'h0000_0008);
    write(1, 6'd3, 32'h2);
    step();
    idle();
    check("wr3b_data", register[3], 32'h2);
    check("wr3b_locked", register_locked, 32'h0);
    check("wr3b_errs", errs(), 32'h0);

    // Write conflict on x9: highest port wins; pulse lasts one cycle
    write(0, 6'd9, 32'hA);
    write(1, 6'd9, 32'hB);
    step();
    idle();
    check("conf_data", register[9], 32'hB);
    check("conf_err", {31'h0, err_write_conflict}, 32'h1);
    step();
    check("conf_pulse_end", errs(), 32'h0);

    // x0 is immutable and silent
    write(0, 6'd0, 32'hFFFF_FFFF);
    lock(1, 6'd0);
    step();
    idle();
    check("x0_data", register[0], 32'h0);
    check("x0_locked", register_locked, 32'h0);
    check("x0_errs", errs(), 32'h0);

    // Saturation of x4's counter at 3
    for (int k = 0; k < 3; k++) begin
      lock(0, 6'd4);
      step();
      check($sformatf("lock4_%0d_ovf", k), {31'h0, err_lock_overflow}, 32'h0);
    end
    lock(0, 6'd4);
    step();
    idle();
    check("lock4_sat_ovf", {31'h0, err_lock_overflow}, 32'h1);
    check("lock4_sat_locked", register_locked, 32'h0000_0010);
    step();
    check("lock4_ovf_end", {31'h0, err_lock_overflow}, 32'h0);
    // Saturated at 3, so exactly three write-backs drain it
    for (int k = 0; k < 3; k++) begin
      write(1, 6'd4, 32'(k + 1));
      step();
      check($sformatf("drain4_%0d_locked", k), register_locked,
            (k == 2) ? 32'h0 : 32'h0000_0010);
    end
    idle();
    check("drain4_data", register[4], 32'h3);
    check("drain4_errs", errs(), 32'h0);

    // Underflow: data lands, flag pulses, lock stays clear; back-to-back holds
    write(0, 6'd10, 32'h55);
    step();
    check("unf1_data", register[10], 32'h55);
    check("unf1_err", {31'h0, err_lock_underflow}, 32'h1);
    check("unf1_locked", register_locked, 32'h0);
    write(0, 6'd10, 32'h66);
    step();
    idle();
    check("unf2_data", register[10], 32'h66);
    check("unf2_err", {31'h0, err_lock_underflow}, 32'h1);
    step();
    check("unf_end", errs(), 32'h0);

    // Same-cycle lock and write on x12: net count unchanged
    lock(0, 6'd12);
    step();
    idle();
    check("lock12_locked", register_locked, 32'h0000_1000);
    lock(0, 6'd12);
    write(1, 6'd12, 32'hC0DE);
    step();
    idle();
    check("lw12_data", register[12], 32'hC0DE);
    check("lw12_locked", register_locked, 32'h0000_1000);
    check("lw12_errs", errs(), 32'h0);
    write(0, 6'd12, 32'hC0DF);
    step();
    idle();
    check("wr12_locked", register_locked, 32'h0);

    // Invalid indices are dropped and flagged
    lock(0, 6'h25);
    step();
    idle();
    check("badlock_err", errs(), 32'h8);
    check("badlock_locked", register_locked, 32'h0);
    write(1, 6'h2A, 32'hBAD0_BAD0);
    step();
    idle();
    check("badwr_err", errs(), 32'h8);
    check("badwr_reg10", register[10], 32'h66);
    step();
    check("bad_end", errs(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
